// File: rtl/code_loader.sv
// code_loader: parses a framed byte stream (16-bit length, N big-endian words,
// XOR checksum byte) into single-cycle writes for the code storage write port.
// Latency: is_write 1 cycle after the W_LO byte; done/error 1 cycle after CHK.
// Backpressure: in_ready is high only while a frame is being received; in_valid low stalls forever.
// Ports: clk/reset (sync, active-high); load_start opens a frame; in_data/in_valid/in_ready
// byte stream; is_write/write_line/write_data storage write; busy/done/error/lines_loaded status.
module code_loader #(
  parameter int code_size     = 12,   // 9..16
  parameter int max_code_line = 100
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_start,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 is_write,
  output logic [31:0]          write_line,
  output logic [code_size-1:0] write_data,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [31:0]          lines_loaded
);

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, W_HI, W_LO, CHK, FAULT
  } state_t;

  localparam logic [31:0] CAPACITY = 32'(max_code_line + 1);

  state_t      state;
  logic [15:0] frame_len;
  logic [7:0]  hi_byte;
  logic [7:0]  chk_acc;
  logic        is_write_q;

  logic        xfer;
  logic [15:0] len_next;
  logic [15:0] word;

  // Receiving states are exactly the busy states.
  assign in_ready = (state == LEN_HI) || (state == LEN_LO) || (state == W_HI) ||
                    (state == W_LO)   || (state == CHK);
  assign busy     = in_ready;
  assign xfer     = in_valid && in_ready;
  assign len_next = {frame_len[15:8], in_data};
  assign word     = {hi_byte, in_data};

  // A write scheduled by the last W_LO byte must not reach storage if reset
  // lands in the cycle it is presented, so the strobe is masked by reset.
  assign is_write = is_write_q && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      frame_len    <= '0;
      hi_byte      <= '0;
      chk_acc      <= '0;
      is_write_q   <= 1'b0;
      write_line   <= '0;
      write_data   <= '0;
      done         <= 1'b0;
      error        <= 1'b0;
      lines_loaded <= '0;
    end else begin
      is_write_q <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE, FAULT: begin
          if (load_start) begin
            state        <= LEN_HI;
            error        <= 1'b0;
            lines_loaded <= '0;
            chk_acc      <= '0;
          end
        end
        LEN_HI: begin
          if (xfer) begin
            frame_len[15:8] <= in_data;
            chk_acc         <= chk_acc ^ in_data;
            state           <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (xfer) begin
            frame_len[7:0] <= in_data;
            chk_acc        <= chk_acc ^ in_data;
            if ({16'd0, len_next} > CAPACITY) begin
              state <= FAULT;
              error <= 1'b1;
            end else if (len_next == 16'd0) begin
              state <= CHK;
            end else begin
              state <= W_HI;
            end
          end
        end
        W_HI: begin
          if (xfer) begin
            hi_byte <= in_data;
            chk_acc <= chk_acc ^ in_data;
            state   <= W_LO;
          end
        end
        W_LO: begin
          if (xfer) begin
            chk_acc      <= chk_acc ^ in_data;
            is_write_q   <= 1'b1;
            write_line   <= lines_loaded;
            write_data   <= word[code_size-1:0];  // upper bits of the byte pair dropped
            lines_loaded <= lines_loaded + 32'd1;
            if (lines_loaded + 32'd1 < {16'd0, frame_len})
              state <= W_HI;
            else
              state <= CHK;
          end
        end
        CHK: begin
          if (xfer) begin
            chk_acc <= chk_acc ^ in_data;
            // Words already written stay written; only the status reflects a bad frame.
            if ((chk_acc ^ in_data) == 8'd0)
              done <= 1'b1;
            else
              error <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
